timer_tick_scheduler: RTL

TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

---
 rtl/timer_tick_scheduler_if.sv | 40 ++++
 rtl/timer_tick_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_tick_scheduler_if
//  Description : Avalon-MM style link between the tick scheduler (master)
//                and a hardware interval timer (slave).
//                  tmr_irq        timer -> sched  level interrupt
//                  tmr_address    sched -> timer  register address
//                  tmr_chipselect sched -> timer  slave select
//                  tmr_write_n    sched -> timer  active-low write strobe
//                  tmr_writedata  sched -> timer  write data
//                  tmr_readdata   timer -> sched  read data, 1-cycle latency
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_tick_scheduler_if;
    logic        tmr_irq;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;

    modport master (
        input  tmr_irq,
        input  tmr_readdata,
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata
    );

    modport slave (
        output tmr_irq,
        output tmr_readdata,
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata
    );
endinterface
`default_nettype wire

// File: rtl/timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_tick_scheduler
//  Description : Services a hardware interval timer and fans its interrupt
//                out to NCH software timer channels. Each serviced interrupt
//                (ACK cycle) is one tick: tick_count advances and every
//                enabled channel counts down, pulsing expire[i] on reload.
//                A host snap_req latches and reads back the timer counter.
//  Ports       : clk, reset      clock, asynchronous active-high reset
//                tmr             timer bus (master modport)
//                cfg_we/sel/period  host write of one channel period
//                snap_req        request a counter snapshot
//                snap_data/valid last snapshot and its update pulse
//                tick_count      serviced interrupt count (wraps)
//                expire          per-channel expiry pulses (ACK cycle only)
//  Revision    : 1.0  initial release
// ============================================================================
module timer_tick_scheduler #(
    parameter int NCH = 4,   // number of channels, 1..8
    parameter int TW  = 16   // period / counter width
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_tick_scheduler_if.master tmr,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_sel,
    input  logic [TW-1:0]          cfg_period,
    input  logic                   snap_req,
    output logic [15:0]            snap_data,
    output logic                   snap_valid,
    output logic [31:0]            tick_count,
    output logic [NCH-1:0]         expire
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACK    = 3'd2,
        S_SNAP_W = 3'd3,
        S_SNAP_R = 3'd4,
        S_SNAP_D = 3'd5
    } state_t;

    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_SNAP    = 3'd4;

    state_t          r_state;
    logic            r_snap_pending;
    logic [15:0]     r_snap_data;
    logic            r_snap_valid;
    logic [31:0]     r_tick_count;
    logic [TW-1:0]   r_period [NCH];
    logic [TW-1:0]   r_count  [NCH];

    logic            w_tick;
    logic [NCH-1:0]  w_cfg_hit;
    logic [NCH-1:0]  w_expire;
    logic [2:0]      w_address;
    logic            w_chipselect;
    logic            w_write_n;
    logic [15:0]     w_writedata;

    assign w_tick = (r_state == S_ACK);

    // ------------------------------------------------------------------------
    // Bus outputs are a pure decode of the state register. Reset forces the
    // idle values so an access in flight is dropped the moment reset rises.
    // ------------------------------------------------------------------------
    always_comb begin
        w_chipselect = 1'b0;
        w_write_n    = 1'b1;
        w_address    = c_ADDR_STATUS;
        w_writedata  = 16'h0000;
        if (!reset) begin
            case (r_state)
                S_INIT: begin
                    // Enable the timer interrupt (control register, ITO bit)
                    w_chipselect = 1'b1;
                    w_write_n    = 1'b0;
                    w_address    = c_ADDR_CONTROL;
                    w_writedata  = 16'h0001;
                end
                S_ACK: begin
                    // Writing the status register clears the timeout flag
                    w_chipselect = 1'b1;
                    w_write_n    = 1'b0;
                end
                S_SNAP_W: begin
                    // Any write to the snap register latches the counter
                    w_chipselect = 1'b1;
                    w_write_n    = 1'b0;
                    w_address    = c_ADDR_SNAP;
                end
                S_SNAP_R: begin
                    w_chipselect = 1'b1;
                    w_address    = c_ADDR_SNAP;
                end
                S_SNAP_D: begin
                    // Read data from SNAP_R arrives during this cycle
                    w_address    = c_ADDR_SNAP;
                end
                default: ;
            endcase
        end
    end

    assign tmr.tmr_chipselect = w_chipselect;
    assign tmr.tmr_write_n    = w_write_n;
    assign tmr.tmr_address    = w_address;
    assign tmr.tmr_writedata  = w_writedata;

    // ------------------------------------------------------------------------
    // Control FSM with registered snapshot / tick outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_snap_pending <= 1'b0;
            r_snap_data    <= 16'h0000;
            r_snap_valid   <= 1'b0;
            r_tick_count   <= 32'd0;
        end else begin
            r_snap_valid <= 1'b0;
            case (r_state)
                S_INIT:   r_state <= S_IDLE;
                S_IDLE: begin
                    // Interrupt wins; the timer holds irq so a snapshot that
                    // delays service never loses a tick.
                    if (tmr.tmr_irq) begin
                        r_state <= S_ACK;
                    end else if (r_snap_pending) begin
                        r_state <= S_SNAP_W;
                    end
                end
                S_ACK: begin
                    r_tick_count <= r_tick_count + 32'd1;
                    r_state      <= S_IDLE;
                end
                S_SNAP_W: r_state <= S_SNAP_R;
                S_SNAP_R: r_state <= S_SNAP_D;
                S_SNAP_D: begin
                    r_snap_data  <= tmr.tmr_readdata;
                    r_snap_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default:  r_state <= S_INIT;
            endcase

            // Requests during W/R merge into the current snapshot; one that
            // lands on SNAP_D is too late to be covered, so it stays pending.
            if (snap_req) begin
                r_snap_pending <= 1'b1;
            end else if (r_state == S_SNAP_D) begin
                r_snap_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel decode. Selects >= NCH match no channel and are dropped.
    // A host write on a tick cycle wins and suppresses that channel's expiry.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_cfg_hit[gi] = cfg_we && (cfg_sel == 3'(gi));
        assign w_expire[gi]  = w_tick && !w_cfg_hit[gi]
                               && (r_period[gi] != '0)
                               && (r_count[gi] == TW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_period[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_period[i] <= cfg_period;
                    r_count[i]  <= cfg_period;
                end else if (w_tick && (r_period[i] != '0)) begin
                    if (r_count[i] == TW'(1)) begin
                        r_count[i] <= r_period[i];
                    end else begin
                        r_count[i] <= r_count[i] - TW'(1);
                    end
                end
            end
        end
    end

    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;
    assign tick_count = r_tick_count;
    assign expire     = w_expire;

endmodule
`default_nettype wire
